lcd_text_ctrl: RTL and testbench

Parametrised HD44780-class character LCD controller in 4-bit mode. It runs the full power-on initialisation itself, then serves a host-side request port for random-access character writes and display clears. It tracks the LCD cursor so that sequential writes skip the redundant set-address command. It sits between application logic (name/score display FSMs, button handlers) and the LCD pins.

---
 rtl/lcd_text_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_lcd_text_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_ctrl.sv
// HD44780-class character LCD controller on a 4-bit bus: runs the power-on
// init itself, then serves random-access character writes and clears.
module lcd_text_ctrl #(
    parameter int ROWS      = 2,
    parameter int COLS      = 16,
    parameter int T_POR     = 3000000,
    parameter int T_INIT2   = 600000,
    parameter int T_SU      = 40000,
    parameter int T_EN      = 100000,
    parameter int T_CLR     = 200000,
    parameter bit CURSOR_ON = 1'b0,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [RW-1:0] wr_row,
    input  logic [5:0]    wr_col,
    input  logic [7:0]    wr_char,
    input  logic          clr_valid,
    output logic          init_done,
    output logic          busy,
    output logic          err,
    output logic [3:0]    data,
    output logic          rs,
    output logic          rw,
    output logic          en
);

    typedef enum logic [2:0] {
        POR_WAIT, INIT_NIB, INIT_CMD, IDLE, SET_ADDR, WR_DATA, CLR_CMD, CLR_WAIT
    } state_t;

    typedef enum logic [1:0] {SETUP, STROBE, HOLD} phase_t;

    localparam logic [7:0] DISP_CMD = CURSOR_ON ? 8'h0F : 8'h0C;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [2:0]    step_q, step_d;
    logic [3:0]    low_q, low_d;
    logic          lo_q, lo_d;
    logic [7:0]    char_q, char_d;
    logic [RW-1:0] req_row_q, req_row_d;
    logic [5:0]    req_col_q, req_col_d;
    logic [RW-1:0] cur_row_q, cur_row_d;
    logic [5:0]    cur_col_q, cur_col_d;
    logic          cur_valid_q, cur_valid_d;
    logic [3:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          en_q, en_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic          load;
    logic [3:0]    load_nib;
    logic          load_rs;
    logic          sending;
    logic          nib_done;
    logic [7:0]    next_cmd;
    logic [6:0]    wr_addr;
    logic          in_range;
    logic          cursor_hit;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    init_cmd = 8'h28;
            3'd1:    init_cmd = 8'h08;
            3'd2:    init_cmd = 8'h01;
            3'd3:    init_cmd = 8'h06;
            default: init_cmd = DISP_CMD;
        endcase
    endfunction

    // Row r starts at DDRAM 0x40*r, so the address is just {row, col}.
    assign wr_addr    = {wr_row[0], wr_col};
    assign in_range   = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    assign cursor_hit = cur_valid_q && (cur_row_q == wr_row) && (cur_col_q == wr_col);
    assign sending    = (state_q == INIT_NIB) || (state_q == INIT_CMD) || (state_q == SET_ADDR)
                     || (state_q == WR_DATA) || (state_q == CLR_CMD);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= POR_WAIT;
            phase_q     <= HOLD;
            cnt_q       <= 32'(T_POR - 1);
            step_q      <= 3'd0;
            low_q       <= 4'h0;
            lo_q        <= 1'b0;
            char_q      <= 8'h00;
            req_row_q   <= '0;
            req_col_q   <= 6'd0;
            cur_row_q   <= '0;
            cur_col_q   <= 6'd0;
            cur_valid_q <= 1'b0;
            data_q      <= 4'h0;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            low_q       <= low_d;
            lo_q        <= lo_d;
            char_q      <= char_d;
            req_row_q   <= req_row_d;
            req_col_q   <= req_col_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
            cur_valid_q <= cur_valid_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        low_d       = low_q;
        lo_d        = lo_q;
        char_d      = char_q;
        req_row_d   = req_row_q;
        req_col_d   = req_col_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
        cur_valid_d = cur_valid_q;
        data_d      = data_q;
        rs_d        = rs_q;
        en_d        = en_q;
        err_d       = 1'b0;
        done_d      = done_q;
        load        = 1'b0;
        load_nib    = 4'h0;
        load_rs     = 1'b0;
        nib_done    = 1'b0;
        next_cmd    = init_cmd(step_q + 3'd1);

        if (sending) begin
            case (phase_q)
                SETUP: begin
                    if (cnt_q == 32'd0) begin
                        phase_d = STROBE;
                        en_d    = 1'b1;
                        cnt_d   = 32'(T_EN - 1);
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                STROBE: begin
                    if (cnt_q == 32'd0) begin
                        phase_d = HOLD;
                        en_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                HOLD:    nib_done = 1'b1;
                default: ;
            endcase
        end

        // Any byte whose high nibble just finished goes on to its low nibble.
        if (nib_done && (state_q != INIT_NIB) && !lo_q) begin
            load     = 1'b1;
            load_nib = low_q;
            load_rs  = rs_q;
            lo_d     = 1'b1;
        end

        case (state_q)
            POR_WAIT: begin
                if (cnt_q == 32'd0) begin
                    state_d  = INIT_NIB;
                    load     = 1'b1;
                    load_nib = 4'h3;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            INIT_NIB: begin
                if (nib_done) begin
                    if (step_q == 3'd0) begin
                        state_d = POR_WAIT;
                        cnt_d   = 32'(T_INIT2 - 1);
                        step_d  = 3'd1;
                    end else if (step_q == 3'd3) begin
                        state_d  = INIT_CMD;
                        step_d   = 3'd0;
                        low_d    = 4'h8;
                        lo_d     = 1'b0;
                        load     = 1'b1;
                        load_nib = 4'h2;
                    end else begin
                        step_d   = step_q + 3'd1;
                        load     = 1'b1;
                        load_nib = (step_q == 3'd2) ? 4'h2 : 4'h3;
                    end
                end
            end
            INIT_CMD: begin
                if (nib_done && lo_q) begin
                    if (step_q == 3'd2) begin
                        state_d = CLR_WAIT;
                        cnt_d   = 32'(T_CLR - 1);
                    end else if (step_q == 3'd4) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        rs_d        = 1'b0;
                        cur_row_d   = '0;
                        cur_col_d   = 6'd0;
                        cur_valid_d = 1'b1;
                    end else begin
                        step_d   = step_q + 3'd1;
                        low_d    = next_cmd[3:0];
                        lo_d     = 1'b0;
                        load     = 1'b1;
                        load_nib = next_cmd[7:4];
                    end
                end
            end
            IDLE: begin
                if (clr_valid) begin
                    state_d  = CLR_CMD;
                    low_d    = 4'h1;
                    lo_d     = 1'b0;
                    load     = 1'b1;
                    load_nib = 4'h0;
                end else if (wr_valid) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else begin
                        req_row_d = wr_row;
                        req_col_d = wr_col;
                        char_d    = wr_char;
                        lo_d      = 1'b0;
                        load      = 1'b1;
                        if (cursor_hit) begin
                            state_d  = WR_DATA;
                            low_d    = wr_char[3:0];
                            load_nib = wr_char[7:4];
                            load_rs  = 1'b1;
                        end else begin
                            state_d  = SET_ADDR;
                            low_d    = wr_addr[3:0];
                            load_nib = {1'b1, wr_addr[6:4]};
                        end
                    end
                end
            end
            SET_ADDR: begin
                if (nib_done && lo_q) begin
                    state_d  = WR_DATA;
                    low_d    = char_q[3:0];
                    lo_d     = 1'b0;
                    load     = 1'b1;
                    load_nib = char_q[7:4];
                    load_rs  = 1'b1;
                end
            end
            WR_DATA: begin
                // Past the last column the LCD's cursor position is not trusted.
                if (nib_done && lo_q) begin
                    state_d     = IDLE;
                    rs_d        = 1'b0;
                    cur_row_d   = req_row_q;
                    cur_col_d   = req_col_q + 6'd1;
                    cur_valid_d = (32'(req_col_q) + 32'd1) != COLS;
                end
            end
            CLR_CMD: begin
                if (nib_done && lo_q) begin
                    state_d = CLR_WAIT;
                    cnt_d   = 32'(T_CLR - 1);
                end
            end
            CLR_WAIT: begin
                if (cnt_q == 32'd0) begin
                    if (done_q) begin
                        state_d     = IDLE;
                        cur_row_d   = '0;
                        cur_col_d   = 6'd0;
                        cur_valid_d = 1'b1;
                    end else begin
                        state_d  = INIT_CMD;
                        step_d   = 3'd3;
                        low_d    = 4'h6;
                        lo_d     = 1'b0;
                        load     = 1'b1;
                        load_nib = 4'h0;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: ;
        endcase

        if (load) begin
            data_d  = load_nib;
            rs_d    = load_rs;
            phase_d = SETUP;
            cnt_d   = 32'(T_SU - 1);
        end
    end

    assign wr_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign init_done = done_q;
    assign err       = err_q;
    assign data      = data_q;
    assign rs        = rs_q;
    assign rw        = 1'b0;
    assign en        = en_q;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Scoreboard bench for lcd_text_ctrl: expected nibbles are queued with each
// stimulus and a monitor pops and compares them on every en falling edge.
module tb_lcd_text_ctrl;

    localparam int ROWS    = 2;
    localparam int COLS    = 16;
    localparam int T_POR   = 20;
    localparam int T_INIT2 = 8;
    localparam int T_SU    = 4;
    localparam int T_EN    = 3;
    localparam int T_CLR   = 10;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       wr_valid, wr_ready, clr_valid, init_done, busy, err, rs, rw, en;
    logic [0:0] wr_row;
    logic [5:0] wr_col;
    logic [7:0] wr_char;
    logic [3:0] data;

    lcd_text_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .T_POR(T_POR), .T_INIT2(T_INIT2),
        .T_SU(T_SU), .T_EN(T_EN), .T_CLR(T_CLR), .CURSOR_ON(1'b0)
    ) dut (
        .clk(clk), .nrst(nrst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char), .clr_valid(clr_valid),
        .init_done(init_done), .busy(busy), .err(err), .data(data),
        .rs(rs), .rw(rw), .en(en)
    );

    always #5 clk = ~clk;

    logic [4:0] exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic       en_prev = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
    endtask

    task automatic pushNib(input logic r, input logic [3:0] n);
        exp_q.push_back({r, n});
    endtask

    task automatic pushByte(input logic r, input logic [7:0] b);
        pushNib(r, b[7:4]);
        pushNib(r, b[3:0]);
    endtask

    // Called at a negedge; returns at the negedge after the request is taken.
    task automatic applyStimulus(input logic do_clr, input logic do_wr, input logic [0:0] row,
                                 input logic [5:0] col, input logic [7:0] ch);
        int budget = 0;
        while (!wr_ready && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (!wr_ready) begin
            timeoutFail("wr_ready before request");
            return;
        end
        clr_valid = do_clr;
        wr_valid  = do_wr;
        wr_row    = row;
        wr_col    = col;
        wr_char   = ch;
        @(negedge clk);
        clr_valid = 1'b0;
        if (do_clr && do_wr) begin
            budget = 0;
            while (!wr_ready && budget < 2000) begin
                @(negedge clk);
                budget++;
            end
            if (!wr_ready) timeoutFail("held write accept");
            @(negedge clk);
        end
        wr_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int budget = 0;
        while (busy && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (busy) timeoutFail(name);
        checkOutput({name, " scoreboard drained"}, exp_q.size(), 0);
    endtask

    // cmd is the hand-computed set-address byte, 0 when none is expected.
    task automatic writeChar(input logic [0:0] row, input logic [5:0] col,
                             input logic [7:0] ch, input logic [7:0] cmd);
        if (cmd != 8'h00) pushByte(1'b0, cmd);
        pushByte(1'b1, ch);
        applyStimulus(1'b0, 1'b1, row, col, ch);
        checkOutput("err on valid write", err, 0);
        waitIdle("write");
        checkOutput("rs back to 0 in idle", rs, 0);
    endtask

    task automatic badWrite(input logic [0:0] row, input logic [5:0] col);
        applyStimulus(1'b0, 1'b1, row, col, 8'h78);
        checkOutput("err pulse", err, 1);
        checkOutput("busy on bad write", busy, 0);
        checkOutput("wr_ready on bad write", wr_ready, 1);
        checkOutput("en on bad write", en, 0);
        @(negedge clk);
        checkOutput("err one cycle", err, 0);
        checkOutput("en after bad write", en, 0);
        checkOutput("busy after bad write", busy, 0);
    endtask

    // Releases reset at a negedge and follows the whole power-on sequence.
    task automatic runInit();
        int n = 0;
        int gap = 0;
        pushNib(1'b0, 4'h3); pushNib(1'b0, 4'h3); pushNib(1'b0, 4'h3); pushNib(1'b0, 4'h2);
        pushByte(1'b0, 8'h28); pushByte(1'b0, 8'h08); pushByte(1'b0, 8'h01);
        pushByte(1'b0, 8'h06); pushByte(1'b0, 8'h0C);
        nrst = 1'b1;
        while (!en && n < 500) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checkOutput("first en rise cycle", n, T_POR + T_SU);
        while (en && gap < 500) begin
            @(negedge clk);
            gap++;
        end
        gap = 0;
        while (!en && gap < 500) begin
            @(negedge clk);
            gap++;
        end
        vectors++;
        if (gap < 10) begin
            miscompares++;
            $display("[TB] FAIL init2 gap: got %0d idle cycles, required at least 10", gap);
        end
        n = 0;
        while (!init_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!init_done) timeoutFail("init_done");
        checkOutput("init scoreboard drained", exp_q.size(), 0);
        checkOutput("busy after init", busy, 0);
        checkOutput("wr_ready after init", wr_ready, 1);
    endtask

    initial begin : monitor
        logic [4:0] got;
        logic [4:0] want;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                en_prev = 1'b0;
            end else begin
                if (en_prev && !en) begin
                    got = {rs, data};
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected nibble: got rs=%0b data=%h, required none", rs, data);
                    end else begin
                        want = exp_q.pop_front();
                        checkOutput("nibble {rs,data}", 32'(got), 32'(want));
                    end
                end
                en_prev = en;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wr_valid  = 1'b0;
        clr_valid = 1'b0;
        wr_row    = 1'b0;
        wr_col    = 6'd0;
        wr_char   = 8'h00;
        nrst      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset en", en, 0);
        checkOutput("reset data", data, 0);
        checkOutput("reset rs", rs, 0);
        checkOutput("reset rw", rw, 0);
        checkOutput("reset wr_ready", wr_ready, 0);
        checkOutput("reset init_done", init_done, 0);
        checkOutput("reset busy", busy, 1);
        checkOutput("reset err", err, 0);

        runInit();

        writeChar(1'b1, 6'd5,  8'h43, 8'hC5);
        writeChar(1'b0, 6'd15, 8'h4B, 8'h8F);
        writeChar(1'b1, 6'd0,  8'h53, 8'hC0);
        writeChar(1'b1, 6'd1,  8'h54, 8'h00);
        writeChar(1'b0, 6'd0,  8'h4D, 8'h80);
        writeChar(1'b0, 6'd1,  8'h41, 8'h00);

        badWrite(1'b0, 6'd16);
        badWrite(1'b1, 6'd63);
        writeChar(1'b0, 6'd2, 8'h42, 8'h00);

        // Clear and write together: clear first, then the held write re-addresses.
        pushByte(1'b0, 8'h01);
        pushByte(1'b0, 8'hC2);
        pushByte(1'b1, 8'h51);
        applyStimulus(1'b1, 1'b1, 1'b1, 6'd2, 8'h51);
        waitIdle("clear then write");

        // Cursor sits at (1,3): the data strobe starts without an address command.
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd3, 8'h58);
        begin
            int budget = 0;
            while (!(rs && en) && budget < 200) begin
                @(negedge clk);
                budget++;
            end
            if (!(rs && en)) timeoutFail("data strobe");
        end
        checkOutput("wr_ready while busy", wr_ready, 0);
        checkOutput("busy during write", busy, 1);
        nrst = 1'b0;
        #1;
        checkOutput("mid-reset en", en, 0);
        checkOutput("mid-reset data", data, 0);
        checkOutput("mid-reset rs", rs, 0);
        checkOutput("mid-reset init_done", init_done, 0);
        checkOutput("mid-reset busy", busy, 1);
        checkOutput("mid-reset scoreboard", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        runInit();
        writeChar(1'b1, 6'd7, 8'h21, 8'hC7);

        repeat (5) @(negedge clk);
        checkOutput("final scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
